// File: rtl/caesar_block_decoder_if.sv
// Handshake and control bundle for caesar_block_decoder: block config, ciphertext in, plaintext out, status.
// csum is present only when CAESAR_BLOCK_CSUM_EN is defined.
interface caesar_block_decoder_if #(
    parameter int LEN_W = 16
);
    logic             start;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_key_sel;
    logic [4:0]       cfg_key;

    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             in_last;

    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             out_last;

    logic             busy;
    logic             done;
    logic             err_len;
`ifdef CAESAR_BLOCK_CSUM_EN
    logic [15:0]      csum;
`endif

    modport master (
        output start, cfg_len, cfg_key_sel, cfg_key,
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last,
        input  busy, done, err_len
`ifdef CAESAR_BLOCK_CSUM_EN
        , input csum
`endif
    );

    modport slave (
        input  start, cfg_len, cfg_key_sel, cfg_key,
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last,
        output busy, done, err_len
`ifdef CAESAR_BLOCK_CSUM_EN
        , output csum
`endif
    );
endinterface

// File: rtl/caesar_block_decoder.sv
// Streaming x-caesar/raw block decoder: rotates letters back by the session key (optional csum: CAESAR_BLOCK_CSUM_EN).
// Latency: accepted byte appears on out_data one cycle later.
// Backpressure: single-entry output register; in_ready = !out_valid || out_ready while running.
module caesar_block_decoder #(
    parameter int LEN_W       = 16,
    parameter int DEFAULT_KEY = 13
) (
    input  logic                 clk,
    input  logic                 rst_n,
    caesar_block_decoder_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [4:0] DEF_K = 5'(DEFAULT_KEY % 26);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LEN_W-1:0] r_rem;
    logic [4:0]       r_key;
    logic [7:0]       r_out_data;
    logic             r_out_valid;
    logic             r_out_last;
    logic             r_done_zero;
    logic             r_err;

    logic             w_in_ready;
    logic             w_acc;
    logic             w_hs;
    logic             w_start_ok;
    logic             w_rem_one;

    function automatic logic [4:0] f_mod26(input logic [4:0] k);
        return (k >= 5'd26) ? (k - 5'd26) : k;
    endfunction

    // Rotate back within the letter's own case; idx+26-k stays positive so one conditional subtract suffices.
    function automatic logic [7:0] f_decode(input logic [7:0] c, input logic [4:0] k);
        logic [7:0] base;
        logic [7:0] idx;
        base     = 8'h00;
        idx      = 8'h00;
        f_decode = c;
        if (c >= 8'h41 && c <= 8'h5A) begin
            base = 8'h41;
        end else if (c >= 8'h61 && c <= 8'h7A) begin
            base = 8'h61;
        end
        if (base != 8'h00) begin
            idx = c - base + 8'd26 - {3'b000, k};
            if (idx >= 8'd26) begin
                idx = idx - 8'd26;
            end
            f_decode = base + idx;
        end
    endfunction

    assign w_rem_one = (r_rem == LEN_W'(1));
    assign w_hs      = r_out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_acc       = 1'b0;
        w_start_ok  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_start_ok = 1'b1;
                    if (bus.cfg_len != '0) begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                w_in_ready = !r_out_valid || bus.out_ready;
                w_acc      = bus.in_valid && w_in_ready;
                if (w_acc && (w_rem_one || bus.in_last)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_hs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem       <= '0;
            r_key       <= 5'd0;
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done_zero <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done_zero <= w_start_ok && (bus.cfg_len == '0);
            if (w_start_ok) begin
                r_rem <= bus.cfg_len;
                r_key <= bus.cfg_key_sel ? f_mod26(bus.cfg_key) : DEF_K;
                r_err <= 1'b0;
            end
            if (w_acc) begin
                r_out_data  <= f_decode(bus.in_data, r_key);
                r_out_valid <= 1'b1;
                r_out_last  <= w_rem_one || bus.in_last;
                r_rem       <= r_rem - LEN_W'(1);
                // Early in_last and missing in_last on the final counted byte are both length errors.
                if (bus.in_last != w_rem_one) begin
                    r_err <= 1'b1;
                end
            end else if (w_hs) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

`ifdef CAESAR_BLOCK_CSUM_EN
    logic [15:0] r_csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csum <= 16'h0000;
        end else if (w_start_ok) begin
            r_csum <= 16'h0000;
        end else if (w_hs) begin
            r_csum <= r_csum + {8'h00, r_out_data};
        end
    end

    assign bus.csum = r_csum;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.busy      = (r_state != S_IDLE);
    // Zero-length blocks complete one cycle after start; real blocks complete on the final output handshake.
    assign bus.done      = r_done_zero || ((r_state == S_DRAIN) && w_hs);
    assign bus.err_len   = r_err;

endmodule

// File: tb/tb_caesar_block_decoder.sv
// Directed scoreboard bench for caesar_block_decoder; expected bytes queued at stimulus, checked by a monitor.
module tb_caesar_block_decoder;

    logic clk;
    logic rst_n;

    caesar_block_decoder_if #(.LEN_W(16)) bus ();

    caesar_block_decoder #(.LEN_W(16), .DEFAULT_KEY(13)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    logic [8:0]  exp_q[$];
    logic [15:0] exp_sum;
    logic        stall_prev = 1'b0;
    logic [8:0]  held;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_dec(input logic [7:0] c, input int k);
        logic [7:0] r;
        r = c;
        for (int j = 0; j < k; j++) begin
            if (r == 8'h41) r = 8'h5A;
            else if (r == 8'h61) r = 8'h7A;
            else if ((r > 8'h41 && r <= 8'h5A) || (r > 8'h61 && r <= 8'h7A)) r = r - 8'd1;
        end
        return r;
    endfunction

    // Monitor: pops the scoreboard on each output handshake and checks hold/ready rules.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (bus.done) done_cnt++;
            if (stall_prev) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_data", {bus.out_last, bus.out_data}, held);
            end
            if (bus.out_valid && !bus.out_ready) chk("in_ready_full", bus.in_ready, 0);
            if (!bus.busy) chk("in_ready_idle", bus.in_ready, 0);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got=%0h want=none", {bus.out_last, bus.out_data});
                end else begin
                    chk("sb_byte", {bus.out_last, bus.out_data}, exp_q.pop_front());
                end
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            held       = {bus.out_last, bus.out_data};
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [7:0] d, input logic l);
        exp_q.push_back({l, d});
        exp_sum = exp_sum + {8'h00, d};
    endtask

    task automatic do_start(input logic [15:0] len, input logic ks, input logic [4:0] k);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.cfg_len = len; bus.cfg_key_sel = ks; bus.cfg_key = k;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = l;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("in_ready_timeout", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int base);
        int n = 0;
        while (done_cnt == base && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(nm, done_cnt - base, 1);
    endtask

    task automatic post_block(input string nm, input logic e);
        @(posedge clk); #1;
        chk({nm, "_busy"}, bus.busy, 0);
        chk({nm, "_err"}, bus.err_len, e);
`ifdef CAESAR_BLOCK_CSUM_EN
        chk({nm, "_csum"}, bus.csum, exp_sum);
`endif
    endtask

    initial begin
        int         base;
        logic [3:0] pat;
        logic [7:0] c;

        rst_n = 1'b0;
        bus.start = 1'b0; bus.cfg_len = '0; bus.cfg_key_sel = 1'b0; bus.cfg_key = 5'd0;
        bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_last = 1'b0; bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err_len, 0);
`ifdef CAESAR_BLOCK_CSUM_EN
        chk("rst_csum", bus.csum, 0);
`endif
        @(posedge clk); #1 rst_n = 1'b1;

        // "ert" -> "reg", key 13
        base = done_cnt; exp_sum = 16'h0;
        push(8'h72, 0); push(8'h65, 0); push(8'h67, 1);
        do_start(16'd3, 1'b0, 5'd0);
        chk("ert_busy", bus.busy, 1);
        chk("ert_pre_valid", bus.out_valid, 0);
        send(8'h65, 0);
        chk("ert_lat_valid", bus.out_valid, 1);
        chk("ert_lat_data", bus.out_data, 8'h72);
        send(8'h72, 0);
        send(8'h74, 1);
        wait_done("ert_done", base);
        post_block("ert", 0);

        // Mixed bytes: upper wrap, lower, punctuation, high byte
        base = done_cnt; exp_sum = 16'h0;
        push(8'h4D, 0); push(8'h6E, 0); push(8'h23, 0); push(8'hC3, 1);
        do_start(16'd4, 1'b0, 5'd0);
        send(8'h5A, 0); send(8'h61, 0); send(8'h23, 0); send(8'hC3, 1);
        wait_done("mix_done", base);
        post_block("mix", 0);

        // Runtime key 29 == 3: "d" -> "a"
        base = done_cnt; exp_sum = 16'h0;
        push(8'h61, 1);
        do_start(16'd1, 1'b1, 5'd29);
        send(8'h64, 1);
        wait_done("key29_done", base);
        post_block("key29", 0);

        // Backpressure 1,0,0,1 on "abcd" -> "nopq"
        base = done_cnt; exp_sum = 16'h0;
        pat = 4'b1001;
        push(8'h6E, 0); push(8'h6F, 0); push(8'h70, 0); push(8'h71, 1);
        do_start(16'd4, 1'b0, 5'd0);
        fork
            begin
                send(8'h61, 0); send(8'h62, 0); send(8'h63, 0); send(8'h64, 1);
            end
            begin
                for (int i = 0; i < 12; i++) begin
                    bus.out_ready = pat[i % 4];
                    @(posedge clk); #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_done("bp_done", base);
        post_block("bp", 0);

        // Zero-length block
        base = done_cnt; exp_sum = 16'h0;
        do_start(16'd0, 1'b0, 5'd0);
        chk("zero_done_pulse", bus.done, 1);
        chk("zero_busy", bus.busy, 0);
        @(posedge clk); #1;
        chk("zero_done_clear", bus.done, 0);
        chk("zero_busy2", bus.busy, 0);
        chk("zero_done_cnt", done_cnt - base, 1);

        // start while busy is ignored: len/key stay 2/13
        base = done_cnt; exp_sum = 16'h0;
        push(8'h6E, 0); push(8'h6F, 1);
        do_start(16'd2, 1'b0, 5'd0);
        send(8'h61, 0);
        do_start(16'd5, 1'b1, 5'd0);
        chk("ign_busy", bus.busy, 1);
        send(8'h62, 1);
        wait_done("ign_done", base);
        post_block("ign", 0);

        // Early in_last: len 5, last on byte 3
        base = done_cnt; exp_sum = 16'h0;
        push(8'h61, 0); push(8'h62, 0); push(8'h63, 1);
        do_start(16'd5, 1'b0, 5'd0);
        send(8'h6E, 0); send(8'h6F, 0); send(8'h70, 1);
        wait_done("early_done", base);
        post_block("early", 1);

        // Missing in_last: len 2
        base = done_cnt; exp_sum = 16'h0;
        push(8'h4E, 0); push(8'h4F, 1);
        do_start(16'd2, 1'b0, 5'd0);
        send(8'h41, 0); send(8'h42, 0);
        wait_done("nolast_done", base);
        post_block("nolast", 1);

        // Next accepted start clears err_len
        do_start(16'd0, 1'b0, 5'd0);
        chk("errclr", bus.err_len, 0);
        @(posedge clk); #1;

        // Reset after byte 2 of a 190-byte block
        base = done_cnt; exp_sum = 16'h0;
        push(8'h4E, 0);
        do_start(16'd190, 1'b0, 5'd0);
        send(8'h41, 0); send(8'h42, 0);
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", bus.out_valid, 0);
        chk("mrst_out_data", bus.out_data, 0);
        chk("mrst_out_last", bus.out_last, 0);
        chk("mrst_busy", bus.busy, 0);
        chk("mrst_in_ready", bus.in_ready, 0);
        chk("mrst_done", bus.done, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("mrst_no_done", done_cnt - base, 0);
        chk("mrst_sb_empty", exp_q.size(), 0);

        // Full 190-byte block, key 31 -> 5
        base = done_cnt; exp_sum = 16'h0;
        for (int i = 0; i < 190; i++) begin
            c = 8'(i * 37 + 11);
            push(ref_dec(c, 5), (i == 189));
        end
        do_start(16'd190, 1'b1, 5'd31);
        for (int i = 0; i < 190; i++) begin
            send(8'(i * 37 + 11), (i == 189));
        end
        wait_done("long_done", base);
        post_block("long", 0);

        repeat (5) @(posedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/caesar_block_decoder.md
Name: caesar_block_decoder

Overview:
Streaming decoder for the data block of a `pragma protect` envelope that uses data_method="x-caesar" with enctype="raw". It sits directly upstream of the tool-side consumer of the decrypted module body. It consumes exactly the byte count declared in the envelope and emits plaintext bytes on a valid/ready stream. Letters are rotated back by the session key (13 for keyname "rot13"); all other bytes pass through unchanged.

Parameters:
LEN_W, 16, width of the byte-count field; maximum block of 2^LEN_W-1 bytes
DEFAULT_KEY, 13, key used when cfg_key_sel=0

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a block; honoured only in IDLE
cfg_len  in  LEN_W  byte count of the block (the "bytes=" value), sampled at start
cfg_key_sel  in  1  0: use DEFAULT_KEY, 1: use cfg_key
cfg_key  in  5  runtime rotation key, sampled at start
in_valid  in  1  ciphertext byte valid
in_ready  out  1  decoder accepts a byte
in_data  in  8  ciphertext byte
in_last  in  1  source marks its final byte
out_valid  out  1  plaintext byte valid
out_ready  in  1  sink accepts a byte
out_data  out  8  plaintext byte
out_last  out  1  final byte of the block
busy  out  1  high in RUN or DRAIN
done  out  1  one-cycle pulse at block completion
err_len  out  1  sticky flag for in_last/count mismatch; cleared by the next accepted start

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, err_len=0; state=IDLE.
- Key: latched at start. The value is reduced modulo 26 (keys 26..31 map to 0..5). Key 0 gives passthrough.
- Decode: 'A'-'Z' maps to 'A'+((c-'A'+26-k) mod 26), and likewise for 'a'-'z'. Every other byte, including 0x80-0xFF, is unchanged. Purely combinational into the output register.
- States:
  - IDLE: in_ready=0. start with cfg_len!=0 latches len and key, clears err_len, and goes to RUN. start with cfg_len=0 pulses done next cycle, clears err_len, and stays in IDLE.
  - RUN: in_ready = !out_valid || out_ready (single-entry output register, full throughput).
    - On accept: out_data <= decode(in_data), out_valid <= 1, remaining decrements.
    - out_last <= 1 when remaining==1 or in_last=1.
    - The last accept moves to DRAIN.
  - DRAIN: in_ready=0. When the final byte handshakes, done pulses in the same cycle, out_valid clears, and the state goes to IDLE.
- Latency: accepted byte appears on out_data the next cycle. out_data/out_valid/out_last are held stable while out_valid && !out_ready.
- Length check:
  - in_last on an accept with remaining>1 sets err_len; the block ends early with that byte carrying out_last.
  - Count reaching 0 with in_last=0 on that byte also sets err_len, but the block still ends.
- start while busy is ignored; cfg_* inputs are not resampled.
- in_valid in IDLE or DRAIN is not accepted and has no effect.
- Counter never wraps: RUN exits at remaining==1, so the maximum length is processed exactly.
- Reset mid-block: everything returns to reset values immediately, and the partial block is discarded with no done pulse.

Optional Feature:
CAESAR_BLOCK_CSUM_EN.
- Defined: adds output csum (16 bits), the modular 16-bit sum of all emitted plaintext bytes of the current block. It is cleared at an accepted start, updated on each output handshake, and valid from the done pulse until the next start. Reset value 0.
- Undefined: the port and adder are absent; behaviour is otherwise identical.

Test Plan:
- Key 13, cfg_len=3, bytes "ert" (0x65,0x72,0x74), in_last on the 3rd, out_ready=1 -> out "reg" (0x72,0x65,0x67), 1-cycle latency, out_last on 3rd, done pulse, err_len=0.
- Key 13, bytes 'Z','a','#',0xC3 -> 'M','n','#',0xC3; cfg_key_sel=1 with key 29 on "d" -> "a" (same as key 3).
- Backpressure: out_ready toggling 1,0,0,1 over a 4-byte block -> out_data stable while stalled, in_ready=0 while the register is full and not draining, no byte lost or duplicated.
- cfg_len=0 start -> done pulse the next cycle, busy stays 0, no out_valid; start asserted while busy -> ignored.
- cfg_len=5 with in_last on byte 3 -> 3 bytes out, out_last on 3rd, err_len=1, done pulses. cfg_len=2 with no in_last -> err_len=1. Next start clears err_len.
- rst_n low after byte 2 of a 190-byte block -> all outputs reset asynchronously, no done. A new 190-byte block then decodes fully with done; with CAESAR_BLOCK_CSUM_EN, csum matches the bench's byte sum.
